// File: rtl/triplet_sequencer.sv
// triplet_sequencer: sweeps all 8 {a,b,c} vectors into a 3-input checker and compares sum against EXPECTED
module triplet_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter logic [7:0] EXPECTED = 8'h82
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       sum,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_vec
);
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
  localparam logic [3:0] SC = 4'(SETTLE_CYCLES);
  state_t state, state_n;
  logic [2:0] idx, idx_n, fv_n;
  logic [3:0] cnt, cnt_n, err_n;
  logic pass_n;
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    err_n = err_count;
    fv_n = fail_vec;
    pass_n = pass;
    case (state)
      IDLE: if (start) begin
        state_n = DRIVE;
        idx_n = 3'd0;
        cnt_n = SC;
        err_n = 4'd0;
        fv_n = 3'd0;
        pass_n = 1'b0;
      end
      DRIVE: begin
        state_n = (cnt <= 4'd1) ? CHECK : DRIVE;
        cnt_n = (cnt <= 4'd1) ? cnt : cnt - 4'd1;
      end
      CHECK: begin
        if (sum != EXPECTED[idx]) begin
          err_n = err_count + 4'd1;
          fv_n = (err_count == 4'd0) ? idx : fail_vec;
        end
        state_n = (idx == 3'd7) ? DONE : DRIVE;
        idx_n = (idx == 3'd7) ? idx : idx + 3'd1;
        cnt_n = SC;
      end
      default: begin
        state_n = IDLE;
        pass_n = (err_count == 4'd0);
      end
    endcase
  end
  // Outputs are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= 3'd0;
      cnt <= 4'd0;
      err_count <= 4'd0;
      fail_vec <= 3'd0;
      pass <= 1'b0;
      {a, b, c} <= 3'd0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      err_count <= err_n;
      fail_vec <= fv_n;
      pass <= pass_n;
      {a, b, c} <= (state == DRIVE || state == CHECK) ? idx : 3'd0;
      busy <= (state != IDLE);
      done <= (state == DONE);
    end
  end
endmodule

// File: tb/tb_triplet_sequencer.sv
// tb_triplet_sequencer: scoreboard bench for the default build and a SETTLE_CYCLES=1 build
module tb_triplet_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, start1 = 1'b0;
  logic a, b, c, sum, busy, done, pass;
  logic a1, b1, c1, sum1, busy1, done1, pass1;
  logic [3:0] err_count, err_count1;
  logic [2:0] fail_vec, fail_vec1;
  logic [1:0] mode = 2'd0, mode1 = 2'd0;
  logic [7:0] good = 8'h82;
  logic [7:0] q0[$], q1[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  // 0: correct checker, 1: stuck at 0, 2: stuck at 1
  assign sum = (mode == 2'd0) ? good[{a, b, c}] : (mode == 2'd2);
  assign sum1 = (mode1 == 2'd0) ? good[{a1, b1, c1}] : (mode1 == 2'd2);

  triplet_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .sum(sum),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_vec(fail_vec)
  );

  triplet_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c(c1), .sum(sum1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1), .fail_vec(fail_vec1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic verdict(input string nm, input logic [7:0] e, input logic p, input logic [3:0] ec, input logic [2:0] fv);
    chk({nm, "_pass"}, p, e[7]);
    chk({nm, "_err_count"}, ec, e[6:3]);
    chk({nm, "_fail_vec"}, fv, e[2:0]);
  endtask

  always @(negedge clk) if (done) begin
    if (q0.size() == 0) chk("unexpected_done", 1, 0);
    else verdict("dut", q0.pop_front(), pass, err_count, fail_vec);
  end

  always @(negedge clk) if (done1) begin
    if (q1.size() == 0) chk("unexpected_done1", 1, 0);
    else verdict("dut1", q1.pop_front(), pass1, err_count1, fail_vec1);
  end

  task automatic run_sweep(input int per);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 8 * per + 1; n++) begin
      @(posedge clk); #1;
      if (n <= 8 * per) chk("vector", {a, b, c}, (n - 1) / per);
      else chk("done_edge", done, 1);
    end
  endtask

  task automatic wait_done();
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1 chk("in_reset", {a, b, c, busy, done, pass, err_count, fail_vec}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("after_reset", {a, b, c, busy, done, pass, err_count, fail_vec}, 0);

    q0.push_back({1'b1, 4'd0, 3'd0});
    run_sweep(3);
    @(posedge clk); #1 chk("busy_after_done", busy, 0);

    mode = 2'd1;
    q0.push_back({1'b0, 4'd2, 3'd1});
    run_sweep(3);
    repeat (3) @(posedge clk);
    #1 chk("hold_err", err_count, 2);
    chk("hold_fv", fail_vec, 1);
    chk("hold_pass", pass, 0);

    mode = 2'd2;
    q0.push_back({1'b0, 4'd6, 3'd0});
    run_sweep(3);
    mode = 2'd0;
    q0.push_back({1'b1, 4'd0, 3'd0});
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("err_cleared", err_count, 0);
    chk("pass_cleared", pass, 0);
    wait_done();
    repeat (2) @(posedge clk);
    #1 chk("pass_hold", pass, 1);

    q0.push_back({1'b1, 4'd0, 3'd0});
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 26; n++) begin
      @(posedge clk); #1;
      if (n == 13) start = 1'b1;
      if (n == 14) begin start = 1'b0; chk("vec4_restart", {a, b, c}, 4); end
      if (n == 24) start = 1'b1;
      if (n == 25) begin start = 1'b0; chk("ignored_done", done, 1); end
      if (n == 26) chk("busy_done_next", {busy, done}, 0);
    end
    repeat (30) @(posedge clk);
    #1 chk("no_extra_sweep", busy, 0);

    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (16) @(posedge clk);
    #1 chk("at_vec5", {a, b, c}, 5);
    #2 rst = 1'b1;
    #1 chk("async_rst", {a, b, c, busy, done, pass, err_count, fail_vec}, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1 chk("idle_after_abort", busy, 0);
    q0.push_back({1'b1, 4'd0, 3'd0});
    run_sweep(3);

    k = 0;
    q1.push_back({1'b1, 4'd0, 3'd0});
    q1.push_back({1'b0, 4'd6, 3'd0});
    q1.push_back({1'b1, 4'd0, 3'd0});
    start1 = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done1) begin
        chk("b2b_done_edge", n, 17 + 18 * k);
        k++;
      end
      if (n == 17) mode1 = 2'd2;
      if (n == 35) mode1 = 2'd0;
      if (n == 53) start1 = 1'b0;
      if (n == 18) chk("b2b_idle", busy1, 0);
      if (n == 19) chk("b2b_restart", busy1, 1);
    end
    chk("b2b_sweeps", k, 3);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/triplet_sequencer.md
TRIPLET_SEQUENCER -- requirements
Module: triplet_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, is the number of clock cycles each vector is held before the result is sampled; legal range 1..15.
REQ-002 Parameter EXPECTED, 8 bits, default 8'h82, holds the expected checker result; bit i is the expected sum for vector {a,b,c} = i.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port start, input, 1 bit: request to run one full 8-vector sweep.
REQ-006 Ports a, b, c, output, 1 bit each: vector bits driven to the downstream 3-input checker; a is the MSB of the vector index.
REQ-007 Port sum, input, 1 bit: checker result for the vector currently driven.
REQ-008 Port busy, output, 1 bit: high while a sweep is in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse at the end of a sweep.
REQ-010 Port pass, output, 1 bit: sweep verdict, valid from done until the next accepted start.
REQ-011 Port err_count, output, 4 bits: number of mismatching vectors in the last or current sweep.
REQ-012 Port fail_vec, output, 3 bits: index of the first mismatching vector; 3'd0 if there is none.

Function
REQ-013 The state machine SHALL have the states IDLE, DRIVE, CHECK and DONE, plus a 3-bit vector index idx and a 4-bit settle counter.
REQ-014 IDLE: a, b and c SHALL be 0 and busy 0. When start=1 is sampled, move to DRIVE with idx=0, clear err_count, fail_vec and pass, and load the settle counter.
REQ-015 DRIVE: {a,b,c} SHALL equal idx, registered with no combinational path from state. After exactly SETTLE_CYCLES cycles in DRIVE, move to CHECK.
REQ-016 CHECK (one cycle, {a,b,c} still equal to idx): sample sum. If sum differs from EXPECTED[idx], increment err_count. On the first mismatch of a sweep only, capture idx into fail_vec.
REQ-017 From CHECK, if idx=7, go to DONE. Otherwise go to DRIVE with idx+1 and reload the settle counter; idx SHALL never wrap inside a sweep.
REQ-018 DONE (one cycle): done=1 and pass=(err_count==0), using the final err_count including the idx=7 check. Then return to IDLE.
REQ-019 busy SHALL be 1 in DRIVE, CHECK and DONE, and 0 in IDLE.
REQ-020 Latency: with start sampled at edge 0, done SHALL be high during the cycle after edge 8*(SETTLE_CYCLES+1)+1. This is edge 25 for the defaults.
REQ-021 start asserted while busy=1 SHALL be ignored, including during DONE. start held high continuously SHALL launch a new sweep from each IDLE cycle.
REQ-022 err_count SHALL NOT saturate; its maximum is 8, which fits in 4 bits.
REQ-023 pass, err_count and fail_vec SHALL hold their values in IDLE until the next accepted start.
REQ-024 fail_vec SHALL update only on the first mismatch. Later mismatches SHALL only increment err_count.

Reset
REQ-025 When rst is asserted, the block SHALL immediately (asynchronously) enter IDLE and force a=b=c=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, idx=0 and the settle counter to 0.
REQ-026 Reset asserted mid-sweep SHALL abort the sweep with no done pulse. The first start after reset is released SHALL begin a fresh sweep at idx=0.

Verification
REQ-027 Correct checker (sum=1 only for vectors 001 and 111), defaults, 1-cycle start pulse -> vectors 0..7 appear in order, each for 3 cycles; done pulses once at edge 25; pass=1, err_count=0, fail_vec=0.
REQ-028 Checker stuck at sum=0 -> pass=0, err_count=2, fail_vec=3'd1.
REQ-029 Checker stuck at sum=1 -> pass=0, err_count=6, fail_vec=3'd0. Then a second sweep with a correct checker -> pass=1 and err_count=0, with the counters cleared at the new start.
REQ-030 start pulsed again at vector 4 and again during DONE -> both are ignored; exactly one done pulse; busy=0 on the cycle after DONE.
REQ-031 rst asserted asynchronously (between clock edges) while idx=5 -> all outputs are 0 before the next edge and no done pulse occurs; start after reset release -> a full sweep from vector 0.
REQ-032 SETTLE_CYCLES=1 with start held high -> back-to-back sweeps of 17 cycles each plus one IDLE cycle between them; the verdict is correct for every sweep.
